tms_prog_mem_arbiter: RTL and testbench

//  Owns the single-port program memory of the TMS1x00 core inside the user project. Shares it

---
 rtl/tms_prog_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_tms_prog_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tms_prog_mem_arbiter.sv
// Program-memory arbiter for the TMS1x00 core: shares one single-port byte RAM between Wishbone and fetch.
// Optional build macro PROG_MEM_WRITE_PROTECT_EN blocks Wishbone memory writes while the core runs.
module tms_prog_mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int STARVE_LIM = 4
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              cpu_fetch_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_instr,
  output logic              cpu_instr_valid,
  output logic              cpu_run_o,
  output logic              cpu_reset_n_o,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, CPU_DATA, WB_RDATA, WB_ACK} state_t;

  localparam int            SW         = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam int            SEL_BIT    = 10;

  state_t            state, state_nxt;
  logic              ctrl_run, ctrl_core_rst;
  logic              stall, wprot;
  logic [15:0]       fetch_cnt;
  logic [SW-1:0]     starve;
  logic              reg_ack;
  logic [31:0]       reg_rdata;

  logic              wb_req, wb_mem_req, wb_reg_req;
  logic              reg_wr, reg_rd, sel_ctrl, sel_status;
  logic              cpu_req, wp_block;
  logic              cpu_grant, wb_grant, wprot_set;
  logic [ADDR_W-1:0] wb_index;
  logic [31:0]       status_word;
  logic              unused;

  assign unused = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

  // The window-select bit lands inside the index slice; clearing it maps window offset 0 to byte 0.
  assign wb_index = wbs_adr_i[ADDR_W+1:2] & ~(ADDR_W'(1) << SEL_BIT);

  assign wb_req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wb_mem_req = wb_req & wbs_adr_i[12];
  assign wb_reg_req = wb_req & ~wbs_adr_i[12];
  assign reg_wr     = wb_reg_req & wbs_we_i;
  assign reg_rd     = wb_reg_req & ~wbs_we_i;
  assign sel_ctrl   = (wbs_adr_i[11:2] == 10'd0);
  assign sel_status = (wbs_adr_i[11:2] == 10'd1);
  assign cpu_req    = ctrl_run & cpu_fetch_req;

`ifdef PROG_MEM_WRITE_PROTECT_EN
  assign wp_block = wbs_we_i & ctrl_run;
`else
  assign wp_block = 1'b0;
`endif

  assign status_word   = {fetch_cnt, 13'd0, wprot, stall, ctrl_run};
  assign cpu_run_o     = ctrl_run;
  assign cpu_reset_n_o = ~ctrl_core_rst;

  assign wbs_ack_o = reg_ack | (state == WB_RDATA) | (state == WB_ACK);
  assign wbs_dat_o = (state == WB_RDATA) ? {24'd0, mem_rdata} :
                     reg_ack             ? reg_rdata          : 32'd0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt       = state;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    cpu_instr       = '0;
    cpu_instr_valid = 1'b0;
    cpu_grant       = 1'b0;
    wb_grant        = 1'b0;
    wprot_set       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req && !(wb_mem_req && starve == STARVE_MAX)) begin
          cpu_grant = 1'b1;
          mem_en    = 1'b1;
          mem_addr  = cpu_addr;
          state_nxt = CPU_DATA;
        end else if (wb_mem_req) begin
          wb_grant = 1'b1;
          if (!wbs_we_i) begin
            mem_en    = 1'b1;
            mem_addr  = wb_index;
            state_nxt = WB_RDATA;
          end else begin
            state_nxt = WB_ACK;
            if (wp_block) begin
              wprot_set = 1'b1;
            end else if (wbs_sel_i[0]) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = wb_index;
              mem_wdata = wbs_dat_i[7:0];
            end
          end
        end
      end
      CPU_DATA: begin
        cpu_instr       = mem_rdata;
        cpu_instr_valid = 1'b1;
        state_nxt       = IDLE;
      end
      WB_RDATA: state_nxt = IDLE;
      WB_ACK:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Starvation counter: only grants taken while Wishbone waits move it toward the limit.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      starve    <= '0;
      fetch_cnt <= '0;
    end else begin
      if (cpu_grant)     starve <= wb_mem_req ? starve + 1'b1 : '0;
      else if (wb_grant) starve <= '0;
      if (state == CPU_DATA) fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_run      <= 1'b0;
      ctrl_core_rst <= 1'b1;
      stall         <= 1'b0;
      wprot         <= 1'b0;
      reg_ack       <= 1'b0;
      reg_rdata     <= '0;
    end else begin
      reg_ack   <= wb_reg_req;
      reg_rdata <= '0;
      if (reg_rd && sel_ctrl)   reg_rdata <= {30'd0, ctrl_core_rst, ctrl_run};
      if (reg_rd && sel_status) reg_rdata <= status_word;
      if (reg_wr && sel_ctrl) begin
        ctrl_run      <= wbs_dat_i[0];
        ctrl_core_rst <= wbs_dat_i[1];
      end
      if (cpu_grant && wb_mem_req)                stall <= 1'b1;
      else if (reg_wr && sel_status && wbs_dat_i[1]) stall <= 1'b0;
      if (wprot_set)                                 wprot <= 1'b1;
      else if (reg_wr && sel_status && wbs_dat_i[2]) wprot <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tms_prog_mem_arbiter.sv
// Directed bench for tms_prog_mem_arbiter: register/memory vector table plus arbitration and reset sequences.
module tb_tms_prog_mem_arbiter;

  localparam int ADDR_W     = 11;
  localparam int STARVE_LIM = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [31:0]       adr, dat;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              cpu_fetch_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_instr;
  logic              cpu_instr_valid, cpu_run_o, cpu_reset_n_o;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  tms_prog_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIM(STARVE_LIM)) dut (
    .wb_clk_i(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .cpu_fetch_req(cpu_fetch_req), .cpu_addr(cpu_addr), .cpu_instr(cpu_instr),
    .cpu_instr_valid(cpu_instr_valid), .cpu_run_o(cpu_run_o), .cpu_reset_n_o(cpu_reset_n_o),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port program memory, zero-filled.
  logic [7:0] ram [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One Wishbone transfer; lat is the index of the sampled cycle carrying ack (0 = stb cycle), -1 on timeout.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rdata, output int lat, output int n_en,
                         output logic [ADDR_W-1:0] last_addr);
    lat = -1; n_en = 0; last_addr = '0; rdata = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (mem_en) begin n_en++; last_addr = mem_addr; end
      if (wbs_ack_o) begin lat = i; rdata = wbs_dat_o; end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  typedef struct {
    logic              we;
    logic [31:0]       adr;
    logic [31:0]       dat;
    logic [3:0]        sel;
    logic [31:0]       exp_rd;
    int                exp_en;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_run;
    logic              exp_rstn;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  logic [31:0]       rd;
  int                lat, n_en, cnt_a, cnt_b;
  logic [ADDR_W-1:0] la;

  initial begin
    cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = '0; dat = '0;
    cpu_fetch_req = 0; cpu_addr = '0;

    //            we    adr         dat           sel   exp_rd        en addr     run  rstn
    vecs[0]  = '{1'b1, 32'h0000, 32'h0000_0001, 4'hF, 32'h0000_0000, 0, 11'h000, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 32'h0000, 32'h0000_0000, 4'hF, 32'h0000_0001, 0, 11'h000, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 32'h0004, 32'h0000_0000, 4'hF, 32'h0000_0001, 0, 11'h000, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 32'h0008, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 0, 11'h000, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 32'h0008, 32'h0000_0000, 4'hF, 32'h0000_0000, 0, 11'h000, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 0, 11'h000, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 32'h1014, 32'h0000_00A5, 4'h1, 32'h0000_0000, 1, 11'h005, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 32'h1014, 32'h0000_0000, 4'h1, 32'h0000_00A5, 1, 11'h005, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 32'h1FFC, 32'h0000_005A, 4'h1, 32'h0000_0000, 1, 11'h3FF, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 32'h1FFC, 32'h0000_0000, 4'h1, 32'h0000_005A, 1, 11'h3FF, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 32'h1014, 32'h0000_0077, 4'hE, 32'h0000_0000, 0, 11'h000, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 32'h1014, 32'h0000_0000, 4'h1, 32'h0000_00A5, 1, 11'h005, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 32'h1018, 32'hFFFF_FF3C, 4'h1, 32'h0000_0000, 1, 11'h006, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 32'h1018, 32'h0000_0000, 4'h1, 32'h0000_003C, 1, 11'h006, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 32'h1000, 32'h0000_0000, 4'h1, 32'h0000_0000, 1, 11'h000, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 32'h0000, 32'h0000_0003, 4'hF, 32'h0000_0000, 0, 11'h000, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 32'h0000, 32'h0000_0000, 4'hF, 32'h0000_0003, 0, 11'h000, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 32'h0000, 32'h0000_0001, 4'hF, 32'h0000_0000, 0, 11'h000, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_run", cpu_run_o, 0);
    check("rst_core_rstn", cpu_reset_n_o, 0);
    check("rst_ack", wbs_ack_o, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_valid", cpu_instr_valid, 0);

    // Fetch requests are ignored while RUN=0
    cpu_fetch_req = 1'b1; cpu_addr = 11'h005; cnt_a = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_en || cpu_instr_valid) cnt_a++;
    end
    cpu_fetch_req = 1'b0;
    check("run0_fetch_ignored", cnt_a, 0);

    wb_xfer(1'b0, 32'h0000, 32'h0, 4'hF, rd, lat, n_en, la);
    check("rst_ctrl", rd, 32'h0000_0002);
    wb_xfer(1'b0, 32'h0004, 32'h0, 4'hF, rd, lat, n_en, la);
    check("rst_status", rd, 32'h0000_0000);

    // Register and memory-window vector table
    for (int k = 0; k < NV; k++) begin
      wb_xfer(vecs[k].we, vecs[k].adr, vecs[k].dat, vecs[k].sel, rd, lat, n_en, la);
      check($sformatf("vec%0d_lat", k), lat, 1);
      check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
      check($sformatf("vec%0d_mem_en", k), n_en, vecs[k].exp_en);
      if (vecs[k].exp_en > 0) check($sformatf("vec%0d_mem_addr", k), la, vecs[k].exp_addr);
      check($sformatf("vec%0d_run", k), cpu_run_o, vecs[k].exp_run);
      check($sformatf("vec%0d_core_rstn", k), cpu_reset_n_o, vecs[k].exp_rstn);
    end

    // Uncontended fetch: grant in the request cycle, data one cycle later
    @(posedge clk); #1;
    cpu_fetch_req = 1'b1; cpu_addr = 11'h005;
    @(negedge clk);
    check("fetch_c0_mem_en", mem_en, 1);
    check("fetch_c0_addr", mem_addr, 11'h005);
    check("fetch_c0_valid", cpu_instr_valid, 0);
    @(negedge clk);
    check("fetch_c1_valid", cpu_instr_valid, 1);
    check("fetch_c1_instr", cpu_instr, 8'hA5);
    @(posedge clk); #1;
    cpu_fetch_req = 1'b0;
    @(negedge clk);
    check("fetch_c2_valid", cpu_instr_valid, 0);
    wb_xfer(1'b0, 32'h0004, 32'h0, 4'hF, rd, lat, n_en, la);
    check("fetch_status", rd, 32'h0001_0001);

    // Starvation: CPU keeps requesting, WB read waits for STARVE_LIM grants
    @(posedge clk); #1;
    cpu_fetch_req = 1'b1; cpu_addr = 11'h005;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1000; sel = 4'h1;
    cnt_a = 0; lat = -1; rd = '0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (cpu_instr_valid) cnt_a++;
      if (wbs_ack_o) begin lat = i; rd = wbs_dat_o; end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; cpu_fetch_req = 1'b0;
    check("starve_cpu_grants", cnt_a, STARVE_LIM);
    check("starve_wb_lat", lat, 2 * STARVE_LIM + 1);
    check("starve_wb_rdata", rd, 32'h0000_0000);
    wb_xfer(1'b0, 32'h0004, 32'h0, 4'hF, rd, lat, n_en, la);
    check("starve_status_stall", rd, 32'h0005_0003);
    wb_xfer(1'b1, 32'h0004, 32'h2, 4'hF, rd, lat, n_en, la);
    wb_xfer(1'b0, 32'h0004, 32'h0, 4'hF, rd, lat, n_en, la);
    check("stall_cleared", rd, 32'h0005_0001);

    // Clearing RUN during CPU_DATA still delivers the fetch, then fetches stop
    @(posedge clk); #1;
    cpu_fetch_req = 1'b1; cpu_addr = 11'h3FF;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000; dat = 32'h0; sel = 4'hF;
    @(negedge clk);
    check("runclr_c0_addr", mem_addr, 11'h3FF);
    @(negedge clk);
    check("runclr_valid", cpu_instr_valid, 1);
    check("runclr_instr", cpu_instr, 8'h5A);
    check("runclr_ack", wbs_ack_o, 1);
    check("runclr_run", cpu_run_o, 0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cnt_a = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_en) cnt_a++;
    end
    cpu_fetch_req = 1'b0;
    check("runclr_no_more_fetch", cnt_a, 0);

    // cyc dropped while the WB request waits behind a CPU grant
    wb_xfer(1'b1, 32'h0000, 32'h1, 4'hF, rd, lat, n_en, la);
    @(posedge clk); #1;
    cpu_fetch_req = 1'b1; cpu_addr = 11'h005;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1020; sel = 4'h1;
    @(negedge clk);
    check("drop_cpu_won", mem_addr, 11'h005);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    cnt_a = 0; cnt_b = 0;
    repeat (8) begin
      @(negedge clk);
      if (wbs_ack_o) cnt_a++;
      if (mem_en && mem_addr == 11'h008) cnt_b++;
    end
    cpu_fetch_req = 1'b0;
    check("drop_no_ack", cnt_a, 0);
    check("drop_no_mem_en", cnt_b, 0);

    // Memory write while RUN=1
    wb_xfer(1'b1, 32'h1014, 32'h3C, 4'h1, rd, lat, n_en, la);
    check("wp_lat", lat, 1);
`ifdef PROG_MEM_WRITE_PROTECT_EN
    check("wp_mem_en", n_en, 0);
    wb_xfer(1'b0, 32'h1014, 32'h0, 4'h1, rd, lat, n_en, la);
    check("wp_readback", rd, 32'h0000_00A5);
    wb_xfer(1'b0, 32'h0004, 32'h0, 4'hF, rd, lat, n_en, la);
    check("wp_status_wprot", rd[2], 1);
`else
    check("wp_mem_en", n_en, 1);
    wb_xfer(1'b0, 32'h1014, 32'h0, 4'h1, rd, lat, n_en, la);
    check("wp_readback", rd, 32'h0000_003C);
    wb_xfer(1'b0, 32'h0004, 32'h0, 4'hF, rd, lat, n_en, la);
    check("wp_status_wprot", rd[2], 0);
`endif
    wb_xfer(1'b1, 32'h0004, 32'h4, 4'hF, rd, lat, n_en, la);
    wb_xfer(1'b0, 32'h0004, 32'h0, 4'hF, rd, lat, n_en, la);
    check("wprot_cleared", rd[2], 0);

    // Asynchronous reset while in WB_RDATA loses the ack
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1014; sel = 4'h1;
    @(negedge clk);
    check("rstmid_grant", mem_en, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    cnt_a = 0;
    repeat (3) begin
      @(negedge clk);
      if (wbs_ack_o) cnt_a++;
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid_no_ack", cnt_a, 0);
    wb_xfer(1'b0, 32'h0000, 32'h0, 4'hF, rd, lat, n_en, la);
    check("rstmid_ctrl", rd, 32'h0000_0002);
    check("rstmid_run", cpu_run_o, 0);
    check("rstmid_core_rstn", cpu_reset_n_o, 0);
    wb_xfer(1'b0, 32'h0004, 32'h0, 4'hF, rd, lat, n_en, la);
    check("rstmid_status", rd, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
